// File: rtl/sprite_bus_pkg.sv
// Shared types for the shared bus driver: FSM state encoding and an index-width helper.
package sprite_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        TURN
    } bus_state_t;

    // Bits needed to index n items; never less than one so single-entry sizes stay legal.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/shared_bus_driver_if.sv
// Request/grant and readback signals shared between the bus driver and its channels.
interface shared_bus_driver_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
);
    logic [CHANNELS-1:0]       req;
    logic [CHANNELS*WIDTH-1:0] wdata;
    logic [CHANNELS-1:0]       grant;
    logic                      bus_oe;
    logic [WIDTH-1:0]          rdata;
    logic                      busy;

    modport master (
        output req, wdata,
        input  grant, bus_oe, rdata, busy
    );

    modport slave (
        input  req, wdata,
        output grant, bus_oe, rdata, busy
    );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester after last_owner, wrapping around.
module rr_arbiter
    import sprite_bus_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int IW       = 2
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [IW-1:0]       last_owner,
    output logic [CHANNELS-1:0] winner,
    output logic [IW-1:0]       winner_idx,
    output logic                any
);

    logic          found;
    logic [IW-1:0] cand;

    // Scanning offsets 1..CHANNELS makes last_owner itself the lowest priority.
    always_comb begin
        winner     = '0;
        winner_idx = '0;
        found      = 1'b0;
        cand       = '0;
        any        = |req;
        for (int i = 1; i <= CHANNELS; i++) begin
            cand = IW'((int'(last_owner) + i) % CHANNELS);
            if (!found && req[cand]) begin
                found       = 1'b1;
                winner[cand] = 1'b1;
                winner_idx  = cand;
            end
        end
    end

endmodule

// File: rtl/shared_bus_driver.sv
// Round-robin owner of a shared tristate bus with a forced turnaround cycle between owners.
module shared_bus_driver
    import sprite_bus_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int MAX_HOLD = 16
) (
    input  logic              clock,
    input  logic              reset,
    shared_bus_driver_if.slave ifc,
    inout  wire  [WIDTH-1:0]  bus
);

    localparam int IW = idx_width(CHANNELS);
    localparam int HW = idx_width(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    bus_state_t          state;
    logic [IW-1:0]       owner;
    logic [IW-1:0]       last_owner;
    logic [HW-1:0]       hold_cnt;
    logic [CHANNELS-1:0] win;
    logic [IW-1:0]       win_idx;
    logic                win_any;
    logic                contended;
    logic [WIDTH-1:0]    drive_data;

    rr_arbiter #(
        .CHANNELS (CHANNELS),
        .IW       (IW)
    ) u_arb (
        .req        (ifc.req),
        .last_owner (last_owner),
        .winner     (win),
        .winner_idx (win_idx),
        .any        (win_any)
    );

    assign contended = |(ifc.req & ~ifc.grant);

    always_comb begin
        drive_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (ifc.grant[i]) drive_data = ifc.wdata[i*WIDTH +: WIDTH];
        end
    end

    assign bus = ifc.bus_oe ? drive_data : {WIDTH{1'bz}};

    // Every output is registered here so grant and bus_oe always change together.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= '0;
            last_owner <= IW'(CHANNELS - 1);
            hold_cnt   <= '0;
            ifc.grant  <= '0;
            ifc.bus_oe <= 1'b0;
            ifc.busy   <= 1'b0;
            ifc.rdata  <= '0;
        end else begin
            if (ifc.bus_oe) ifc.rdata <= bus;
            case (state)
                IDLE, TURN: begin
                    if (win_any) begin
                        state      <= DRIVE;
                        owner      <= win_idx;
                        last_owner <= win_idx;
                        hold_cnt   <= '0;
                        ifc.grant  <= win;
                        ifc.bus_oe <= 1'b1;
                        ifc.busy   <= 1'b1;
                    end else begin
                        state      <= IDLE;
                        ifc.grant  <= '0;
                        ifc.bus_oe <= 1'b0;
                        ifc.busy   <= 1'b0;
                    end
                end
                DRIVE: begin
                    if (!ifc.req[owner] || (hold_cnt == HOLD_LAST && contended)) begin
                        state      <= TURN;
                        ifc.grant  <= '0;
                        ifc.bus_oe <= 1'b0;
                        ifc.busy   <= 1'b1;
                    end else if (hold_cnt != HOLD_LAST) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    ifc.grant  <= '0;
                    ifc.bus_oe <= 1'b0;
                    ifc.busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/shared_bus_driver.md
SHARED_BUS_DRIVER -- requirements
Module: shared_bus_driver

Interface
REQ-001 Parameter WIDTH, default 8: bus data width in bits; SHALL be >= 1.
REQ-002 Parameter CHANNELS, default 4: number of requesting channels; SHALL be >= 1.
REQ-003 Parameter MAX_HOLD, default 16: DRIVE cycles after which a contended owner is forced off; SHALL be >= 1.
REQ-004 clock  in  1  sole clock; all state changes on the rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 req  in  CHANNELS  level request; bit i high means channel i wants the bus.
REQ-007 wdata  in  CHANNELS*WIDTH  channel i write data at bits [i*WIDTH +: WIDTH].
REQ-008 bus  inout  WIDTH  shared tristate bus; high-impedance unless bus_oe is 1.
REQ-009 grant  out  CHANNELS  one-hot registered owner indication; all-zero when no owner.
REQ-010 bus_oe  out  1  registered output enable; 1 only in DRIVE.
REQ-011 rdata  out  WIDTH  registered copy of bus, captured while bus_oe is 1.
REQ-012 busy  out  1  1 in DRIVE or TURN.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, DRIVE, TURN.
REQ-014 IDLE: bus Z, grant 0; any req bit high -> DRIVE next edge with the round-robin winner granted (1-cycle request-to-grant latency).
REQ-015 Round-robin: search starts at last_owner+1, wraps modulo CHANNELS; first high req wins; last_owner updates on every grant.
REQ-016 DRIVE: bus = owner's wdata slice, combinationally from wdata gated by registered bus_oe; grant holds owner bit.
REQ-017 DRIVE -> TURN when req[owner] is 0, or when hold_cnt == MAX_HOLD-1 and any other req bit is 1.
REQ-018 hold_cnt clears on DRIVE entry, increments per DRIVE cycle, saturates at MAX_HOLD-1; an uncontended owner keeps the bus indefinitely.
REQ-019 TURN lasts exactly one cycle with bus_oe 0 and grant 0; no two owners are ever adjacent without a TURN cycle.
REQ-020 TURN -> DRIVE with new round-robin winner if any req high (the just-released owner is eligible only if no other channel requests), else -> IDLE.
REQ-021 Owner dropping req in the same cycle others raise req: TURN still occurs; arbitration happens in TURN.
REQ-022 Owner's req low in first DRIVE cycle: DRIVE is held that one cycle, then TURN.
REQ-023 CHANNELS = 1: same FSM; release always passes through TURN.
REQ-024 rdata <= bus on each edge where bus_oe is 1; otherwise holds.
REQ-025 grant SHALL never have more than one bit set; bus_oe = |grant at all times.

Reset
REQ-026 Reset assertion SHALL immediately force state IDLE, grant 0, bus_oe 0 (bus Z), busy 0, rdata 0, hold_cnt 0, last_owner CHANNELS-1 (channel 0 wins first).
REQ-027 Reset mid-DRIVE SHALL release the bus in the same cycle without a TURN; first grant after release follows REQ-014.

Structure
REQ-028 Package sprite_bus_pkg SHALL hold the state enumeration typedef and an index-width constant function (ceil log2, minimum 1).
REQ-029 One combinational sub-module rr_arbiter (inputs req, last_owner; outputs one-hot winner, winner index, any) SHALL implement REQ-015.
REQ-030 Tristate driving SHALL be a single continuous assignment on bus in the top module.

Verification
REQ-031 Reset release, req=4'b0100 -> grant=4'b0100, bus_oe=1 one cycle later; bus equals wdata[23:16].
REQ-032 req=4'b1111 held, MAX_HOLD=4 -> owners 0,1,2,3,0 in order, each DRIVE 4 cycles, one TURN cycle (bus Z) between each.
REQ-033 Only channel 2 requesting for 40 cycles -> grant stays 4'b0100, no TURN, hold_cnt saturates at 3.
REQ-034 Owner 1 drops req same cycle channel 3 raises -> one TURN cycle, then grant=4'b1000; never two grant bits set.
REQ-035 reset pulsed mid-DRIVE -> bus_oe and grant 0 without waiting for a clock edge; rdata 0; next grant to channel 0 if requesting.
REQ-036 Owner drives 8'hA5 for 3 cycles then releases -> rdata=8'hA5 and holds through TURN and IDLE.
